// File: rtl/hpu_ctrl_pkg.sv
// Shared definitions for the HPU control/status register block: register offsets,
// slave FSM encoding, AXI response codes and byte-lane helpers.
package hpu_ctrl_pkg;

  localparam logic [11:0] OFF_CTRL     = 12'h000;
  localparam logic [11:0] OFF_ADDR_NUM = 12'h004;
  localparam logic [11:0] OFF_ADDR_I   = 12'h008;
  localparam logic [11:0] OFF_ADDR_J   = 12'h00C;
  localparam logic [11:0] OFF_SCRATCH  = 12'h010;
  localparam logic [11:0] OFF_RAND     = 12'h014;
  localparam logic [11:0] OFF_STATUS   = 12'h018;
  localparam logic [11:0] OFF_DONE_CNT = 12'h01C;

  // Word index within the 8-register window.
  localparam logic [2:0] IDX_CTRL     = OFF_CTRL[4:2];
  localparam logic [2:0] IDX_ADDR_NUM = OFF_ADDR_NUM[4:2];
  localparam logic [2:0] IDX_ADDR_I   = OFF_ADDR_I[4:2];
  localparam logic [2:0] IDX_ADDR_J   = OFF_ADDR_J[4:2];
  localparam logic [2:0] IDX_SCRATCH  = OFF_SCRATCH[4:2];
  localparam logic [2:0] IDX_RAND     = OFF_RAND[4:2];
  localparam logic [2:0] IDX_STATUS   = OFF_STATUS[4:2];
  localparam logic [2:0] IDX_DONE_CNT = OFF_DONE_CNT[4:2];

  typedef enum logic [2:0] {
    ST_INI,
    ST_AW,
    ST_W,
    ST_AWW,
    ST_AR1,
    ST_AR2
  } axil_state_e;

  typedef logic [1:0] axi_resp_t;
  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  // Only offsets 0x00..0x1C are backed by registers.
  function automatic logic is_mapped(input logic [6:0] addr_hi);
    return addr_hi == 7'd0;
  endfunction

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [31:0] mask);
    return (old_word & ~mask) | (new_word & mask);
  endfunction

endpackage

// File: rtl/hpu_ctrl_regs_if.sv
// AXI4-Lite bus between the PS master and the HPU control register block.
interface hpu_ctrl_regs_if;

  logic [11:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [11:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

endinterface

// File: rtl/axil_slave_fsm.sv
// AXI4-Lite slave handshake FSM: captures address/data and issues a one-cycle
// write-commit strobe on entry to AWW and a read strobe in AR1.
module axil_slave_fsm
  import hpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] aw_addr,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic [31:0] w_data,
  input  logic [3:0]  w_strb,
  input  logic        w_valid,
  output logic        w_ready,
  output logic        b_valid,
  input  logic        b_ready,
  input  logic [11:0] ar_addr,
  input  logic        ar_valid,
  output logic        ar_ready,
  output logic        r_valid,
  input  logic        r_ready,
  output logic        wr_en,
  output logic [11:0] wr_addr,
  output logic [31:0] wr_data,
  output logic [3:0]  wr_strb,
  output logic        rd_en,
  output logic [11:0] rd_addr
);

  axil_state_e state, state_nxt;

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_INI;
      wr_en <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_en <= (state_nxt == ST_AWW) && (state != ST_AWW);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    ar_ready  = 1'b0;
    b_valid   = 1'b0;
    r_valid   = 1'b0;
    rd_en     = 1'b0;
    unique case (state)
      ST_INI: begin
        aw_ready = 1'b1;
        w_ready  = 1'b1;
        ar_ready = 1'b1;
        if (aw_valid && w_valid) state_nxt = ST_AWW;
        else if (aw_valid)       state_nxt = ST_AW;
        else if (w_valid)        state_nxt = ST_W;
        else if (ar_valid)       state_nxt = ST_AR1;
      end
      ST_AW: begin
        w_ready = 1'b1;
        if (w_valid) state_nxt = ST_AWW;
      end
      ST_W: begin
        aw_ready = 1'b1;
        if (aw_valid) state_nxt = ST_AWW;
      end
      ST_AWW: begin
        b_valid = 1'b1;
        if (b_ready) state_nxt = ST_INI;
      end
      ST_AR1: begin
        rd_en     = 1'b1;
        state_nxt = ST_AR2;
      end
      ST_AR2: begin
        r_valid = 1'b1;
        if (r_ready) state_nxt = ST_INI;
      end
      default: state_nxt = ST_INI;
    endcase
  end

  // NOTE: capture registers carry no reset; they are only consumed while the
  // FSM state qualifies them, so their power-up contents never reach software.
  always_ff @(posedge clk) begin
    if (aw_valid && aw_ready) wr_addr <= aw_addr;
    if (w_valid && w_ready) begin
      wr_data <= w_data;
      wr_strb <= w_strb;
    end
    if (state == ST_INI && state_nxt == ST_AR1) rd_addr <= ar_addr;
  end

endmodule

// File: rtl/hpu_ctrl_regs.sv
// HPU control/status register file behind an AXI4-Lite slave.
// Define HPU_CTRL_WSTRB_EN to honour S_AXI_WSTRB byte lanes on every register.
module hpu_ctrl_regs
  import hpu_ctrl_pkg::*;
#(
  parameter int ADDR_W        = 19,
  parameter int RAND_W        = 16,
  parameter int MAT_A_W       = 7,
  parameter int ADDR_NUM_INIT = 11,
  parameter int ADDR_I_INIT   = 7,
  parameter int ADDR_J_INIT   = 2,
  parameter int RAND_INIT     = 99
) (
  input  logic               clk,
  input  logic               rst,
  hpu_ctrl_regs_if.slave     s_axi,
  input  logic [MAT_A_W-1:0] mat_a,
  input  logic               done_pulse,
  output logic               matw,
  output logic               run,
  output logic               last,
  output logic [ADDR_W-1:0]  addr_num,
  output logic [ADDR_W:0]    addr_i,
  output logic [ADDR_W:0]    addr_j,
  output logic [RAND_W-1:0]  random_num
);

  logic        wr_en, rd_en;
  logic [11:0] wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;

  axil_slave_fsm u_fsm (
    .clk      (clk),
    .rst      (rst),
    .aw_addr  (s_axi.S_AXI_AWADDR),
    .aw_valid (s_axi.S_AXI_AWVALID),
    .aw_ready (s_axi.S_AXI_AWREADY),
    .w_data   (s_axi.S_AXI_WDATA),
    .w_strb   (s_axi.S_AXI_WSTRB),
    .w_valid  (s_axi.S_AXI_WVALID),
    .w_ready  (s_axi.S_AXI_WREADY),
    .b_valid  (s_axi.S_AXI_BVALID),
    .b_ready  (s_axi.S_AXI_BREADY),
    .ar_addr  (s_axi.S_AXI_ARADDR),
    .ar_valid (s_axi.S_AXI_ARVALID),
    .ar_ready (s_axi.S_AXI_ARREADY),
    .r_valid  (s_axi.S_AXI_RVALID),
    .r_ready  (s_axi.S_AXI_RREADY),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_strb  (wr_strb),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr)
  );

  logic [31:0] wr_mask;
  logic        unused_bits;
`ifdef HPU_CTRL_WSTRB_EN
  assign wr_mask     = strb_mask(wr_strb);
  assign unused_bits = ^{wr_addr[1:0], rd_addr[1:0]};
`else
  assign wr_mask     = '1;
  assign unused_bits = ^{wr_strb, wr_addr[1:0], rd_addr[1:0]};
`endif

  logic [2:0]        ctrl_q;
  logic [ADDR_W-1:0] addr_num_q;
  logic [ADDR_W:0]   addr_i_q, addr_j_q;
  logic [31:0]       scratch_q;
  logic [RAND_W-1:0] random_q;
  logic              done_q;
  logic [31:0]       done_cnt_q, done_cnt_nxt;

  logic [2:0]  wr_idx, rd_idx;
  logic        wr_hit, rd_mapped;
  logic [31:0] reg_view [8];
  logic [31:0] wr_word;

  assign wr_idx    = wr_addr[4:2];
  assign rd_idx    = rd_addr[4:2];
  assign wr_hit    = wr_en && is_mapped(wr_addr[11:5]);
  assign rd_mapped = is_mapped(rd_addr[11:5]);

  always_comb begin
    reg_view[IDX_CTRL]     = {29'd0, ctrl_q};
    reg_view[IDX_ADDR_NUM] = 32'(addr_num_q);
    reg_view[IDX_ADDR_I]   = 32'(addr_i_q);
    reg_view[IDX_ADDR_J]   = 32'(addr_j_q);
    reg_view[IDX_SCRATCH]  = scratch_q;
    reg_view[IDX_RAND]     = 32'(random_q);
    reg_view[IDX_STATUS]   = {29'd0, ctrl_q[1], ctrl_q[0], done_q};
    reg_view[IDX_DONE_CNT] = done_cnt_q;
  end

  // Partial-lane writes keep the untouched bytes of the current value.
  assign wr_word = merge_bytes(reg_view[wr_idx], wr_data, wr_mask);

  // A clear and a completion in the same cycle leave the count at one.
  always_comb begin
    done_cnt_nxt = done_cnt_q;
    if (wr_hit && wr_idx == IDX_DONE_CNT) done_cnt_nxt = done_cnt_q & ~wr_mask;
    done_cnt_nxt = done_cnt_nxt + 32'(done_pulse);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q     <= '0;
      addr_num_q <= ADDR_W'(ADDR_NUM_INIT);
      addr_i_q   <= (ADDR_W+1)'(ADDR_I_INIT);
      addr_j_q   <= (ADDR_W+1)'(ADDR_J_INIT);
      scratch_q  <= '0;
      random_q   <= RAND_W'(RAND_INIT);
      done_q     <= 1'b0;
      done_cnt_q <= '0;
    end else begin
      // Auto-clear is listed first so a same-cycle software write overrides it.
      if (ctrl_q[0] && mat_a == random_q[MAT_A_W-1:0]) ctrl_q[0] <= 1'b0;
      if (wr_hit) begin
        case (wr_idx)
          IDX_CTRL:     ctrl_q     <= wr_word[2:0];
          IDX_ADDR_NUM: addr_num_q <= wr_word[ADDR_W-1:0];
          IDX_ADDR_I:   addr_i_q   <= wr_word[ADDR_W:0];
          IDX_ADDR_J:   addr_j_q   <= wr_word[ADDR_W:0];
          IDX_SCRATCH:  scratch_q  <= wr_word;
          IDX_RAND:     random_q   <= wr_word[RAND_W-1:0];
          IDX_STATUS:   if (wr_data[0] && wr_mask[0]) done_q <= 1'b0;
          default:      ;
        endcase
      end
      if (done_pulse) done_q <= 1'b1;
      done_cnt_q <= done_cnt_nxt;
    end
  end

  logic [31:0] rdata_q;
  axi_resp_t   rresp_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (rd_en) begin
      rdata_q <= rd_mapped ? reg_view[rd_idx] : '0;
      rresp_q <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign s_axi.S_AXI_RDATA = rdata_q;
  assign s_axi.S_AXI_RRESP = rresp_q;
  assign s_axi.S_AXI_BRESP = is_mapped(wr_addr[11:5]) ? RESP_OKAY : RESP_SLVERR;

  assign matw       = ctrl_q[0];
  assign run        = ctrl_q[1];
  assign last       = ctrl_q[2];
  assign addr_num   = addr_num_q;
  assign addr_i     = addr_i_q;
  assign addr_j     = addr_j_q;
  assign random_num = random_q;

endmodule
